rf_write_arbiter: RTL

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_write_arbiter_pkg.sv | 12 +
 rtl/rf_scoreboard.sv | 30 +++
 rtl/rf_write_arbiter.sv | 98 +++++++++
 3 files changed

// File: rtl/rf_write_arbiter_pkg.sv
// Shared CPU definitions for the register-file write path: widths and the
// writeback port identifiers used by the arbiter.
package rf_write_arbiter_pkg;
  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int RIDX_W = $clog2(NREG);

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write scoreboard: decode marks a destination busy,
// the register-file write clears it; a same-edge mark beats the clear.
module rf_scoreboard #(
  parameter int NREG = rf_write_arbiter_pkg::NREG
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mark_valid,
  input  logic [$clog2(NREG)-1:0] mark_rd,
  input  logic                    clr_valid,
  input  logic [$clog2(NREG)-1:0] clr_rd,
  output logic [NREG-1:0]         busy
);
  logic [NREG-1:0] set_mask, clr_mask, busy_nxt;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (mark_valid) set_mask[mark_rd] = 1'b1;
    if (clr_valid)  clr_mask[clr_rd]  = 1'b1;
    busy_nxt    = (busy & ~clr_mask) | set_mask;
    // x0 is hardwired zero, so it can never have a pending write
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// Two-port writeback arbiter in front of the single register-file write port.
// Each port has a one-entry skid slot; contention is resolved round-robin.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int XLEN = rf_write_arbiter_pkg::XLEN,
  parameter int NREG = rf_write_arbiter_pkg::NREG
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [$clog2(NREG)-1:0] a_rd,
  input  logic [XLEN-1:0]         a_data,
  input  logic                    b_valid,
  output logic                    b_ready,
  input  logic [$clog2(NREG)-1:0] b_rd,
  input  logic [XLEN-1:0]         b_data,
  output logic                    wr_en,
  output logic [$clog2(NREG)-1:0] wr_rd,
  output logic [XLEN-1:0]         wr_data,
  input  logic                    mark_valid,
  input  logic [$clog2(NREG)-1:0] mark_rd,
  output logic [NREG-1:0]         busy
);
  localparam int RW = $clog2(NREG);

  logic            a_full, b_full;
  logic [RW-1:0]   a_slot_rd, b_slot_rd;
  logic [XLEN-1:0] a_slot_data, b_slot_data;
  port_e           prio;
  logic            grant_a, grant_b, grant_any;

  // Grant depends only on registered state, so ready never loops through valid
  assign grant_a   = a_full && (!b_full || prio == PORT_A);
  assign grant_b   = b_full && (!a_full || prio == PORT_B);
  assign grant_any = grant_a || grant_b;

  assign a_ready = !a_full || grant_a;
  assign b_ready = !b_full || grant_b;

  always_comb begin
    wr_rd   = '0;
    wr_data = '0;
    if (grant_a) begin
      wr_rd   = a_slot_rd;
      wr_data = a_slot_data;
    end else if (grant_b) begin
      wr_rd   = b_slot_rd;
      wr_data = b_slot_data;
    end
    wr_en = grant_any && (wr_rd != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_full      <= 1'b0;
      a_slot_rd   <= '0;
      a_slot_data <= '0;
    end else if (a_valid && a_ready) begin
      a_full      <= 1'b1;
      a_slot_rd   <= a_rd;
      a_slot_data <= a_data;
    end else if (grant_a) begin
      a_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_full      <= 1'b0;
      b_slot_rd   <= '0;
      b_slot_data <= '0;
    end else if (b_valid && b_ready) begin
      b_full      <= 1'b1;
      b_slot_rd   <= b_rd;
      b_slot_data <= b_data;
    end else if (grant_b) begin
      b_full <= 1'b0;
    end
  end

  // Priority only moves when the loser was actually waiting
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  prio <= PORT_A;
    else if (a_full && b_full) prio <= grant_a ? PORT_B : PORT_A;
  end

  rf_scoreboard #(.NREG(NREG)) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .mark_valid (mark_valid),
    .mark_rd    (mark_rd),
    .clr_valid  (wr_en),
    .clr_rd     (wr_rd),
    .busy       (busy)
  );
endmodule
